// File: rtl/gray_synchronizer_pkg.sv
// Shared helpers for the gray-code synchronizer slice.
// gray_to_binary / binary_to_gray / popcount work on MaxWidth-bit vectors.
// Callers zero-extend narrower codes. Leading zeros decode to zeros, so callers can
// truncate the result back to their own WIDTH. WIDTH must therefore not exceed MaxWidth.
package gray_synchronizer_pkg;

  localparam int unsigned MaxWidth = 32;
  localparam int unsigned PopWidth = $clog2(MaxWidth + 1);

  function automatic logic [MaxWidth-1:0] gray_to_binary(input logic [MaxWidth-1:0] gray);
    logic [MaxWidth-1:0] bin;
    bin[MaxWidth-1] = gray[MaxWidth-1];
    for (int i = MaxWidth - 2; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

  function automatic logic [MaxWidth-1:0] binary_to_gray(input logic [MaxWidth-1:0] bin);
    return bin ^ (bin >> 1);
  endfunction

  function automatic logic [PopWidth-1:0] popcount(input logic [MaxWidth-1:0] v);
    logic [PopWidth-1:0] n;
    n = '0;
    for (int i = 0; i < MaxWidth; i++) begin
      n = n + PopWidth'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/multichannel_gray_synchronizer_if.sv
// Bus bundle for multichannel_gray_synchronizer.
//   gray_in     : CHANNELS*WIDTH asynchronous gray codes, channel c at [c*WIDTH +: WIDTH]
//   error_clear : per-channel clear of the sticky error flag
//   binary_out  : decoded synchronized values
//   delta       : (new - previous) mod 2^WIDTH, valid while change=1
//   change      : one-cycle strobe per channel
//   error       : sticky multi-bit-move flag per channel
// master = gray source / consumer side, slave = the synchronizer.
interface multichannel_gray_synchronizer_if #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4
);
  logic [CHANNELS*WIDTH-1:0] gray_in;
  logic [CHANNELS-1:0]       error_clear;
  logic [CHANNELS*WIDTH-1:0] binary_out;
  logic [CHANNELS*WIDTH-1:0] delta;
  logic [CHANNELS-1:0]       change;
  logic [CHANNELS-1:0]       error;

  modport master (
    output gray_in, error_clear,
    input  binary_out, delta, change, error
  );

  modport slave (
    input  gray_in, error_clear,
    output binary_out, delta, change, error
  );
endinterface

// File: rtl/gray_synchronizer_channel.sv
// One channel of the gray synchronizer: STAGES-deep bit-parallel sync chain, previous-code
// register, decode, modular delta, change strobe and sticky multi-bit error.
//   clock, reset   : destination clock, async active-high reset
//   gray_i         : asynchronous gray code
//   error_clear_i  : clears the sticky error (a same-cycle set wins)
//   binary_o       : decoded value, updated STAGES edges after capture
//   delta_o        : (new - previous) mod 2^WIDTH while change_o=1, else 0
//   change_o       : one-cycle strobe when the synchronized code moved
//   error_o        : sticky, code moved by more than one bit
module gray_synchronizer_channel
  import gray_synchronizer_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] gray_i,
  input  logic             error_clear_i,
  output logic [WIDTH-1:0] binary_o,
  output logic [WIDTH-1:0] delta_o,
  output logic             change_o,
  output logic             error_o
);

  logic [STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] prev_q, prev_d;
  logic [WIDTH-1:0] binary_q, binary_d;
  logic [WIDTH-1:0] delta_q, delta_d;
  logic             change_q, change_d;
  logic             error_q, error_d;

  logic [WIDTH-1:0]    cur, cur_bin, prev_bin;
  logic [PopWidth-1:0] hd;

  always_comb begin
    sync_d    = sync_q;
    sync_d[0] = gray_i;
    for (int s = 1; s < STAGES; s++) begin
      sync_d[s] = sync_q[s-1];
    end

    cur      = sync_q[STAGES-1];
    cur_bin  = WIDTH'(gray_to_binary(MaxWidth'(cur)));
    prev_bin = WIDTH'(gray_to_binary(MaxWidth'(prev_q)));
    hd       = popcount(MaxWidth'(cur ^ prev_q));

    prev_d   = cur;
    binary_d = binary_q;
    delta_d  = '0;
    change_d = 1'b0;
    if (hd != '0) begin
      binary_d = cur_bin;
      delta_d  = cur_bin - prev_bin;
      change_d = 1'b1;
    end
    // Set has priority over a coincident clear.
    error_d = (hd > PopWidth'(1)) | (error_q & ~error_clear_i);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q   <= '0;
      prev_q   <= '0;
      binary_q <= '0;
      delta_q  <= '0;
      change_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      prev_q   <= prev_d;
      binary_q <= binary_d;
      delta_q  <= delta_d;
      change_q <= change_d;
      error_q  <= error_d;
    end
  end

  assign binary_o = binary_q;
  assign delta_o  = delta_q;
  assign change_o = change_q;
  assign error_o  = error_q;

endmodule

// File: rtl/multichannel_gray_synchronizer.sv
// Receiver for CHANNELS independent gray-coded counters from foreign clock domains.
//   clock, reset : destination clock, async active-high reset
//   bus (slave)  : gray_in / error_clear in, binary_out / delta / change / error out,
//                  channel c occupying slice [c*WIDTH +: WIDTH] or bit c.
// Each channel is a self-contained gray_synchronizer_channel; this level only wires slices.
module multichannel_gray_synchronizer #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned STAGES   = 2,
  parameter int unsigned CHANNELS = 4
) (
  input logic                            clock,
  input logic                            reset,
  multichannel_gray_synchronizer_if.slave bus
);

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    gray_synchronizer_channel #(
      .WIDTH  (WIDTH),
      .STAGES (STAGES)
    ) u_ch (
      .clock         (clock),
      .reset         (reset),
      .gray_i        (bus.gray_in[c*WIDTH +: WIDTH]),
      .error_clear_i (bus.error_clear[c]),
      .binary_o      (bus.binary_out[c*WIDTH +: WIDTH]),
      .delta_o       (bus.delta[c*WIDTH +: WIDTH]),
      .change_o      (bus.change[c]),
      .error_o       (bus.error[c])
    );
  end

endmodule

// File: tb/tb_multichannel_gray_synchronizer.sv
module tb_multichannel_gray_synchronizer;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int C    = 4;
  localparam int Half = 50;

  typedef struct packed {
    logic [7:0] bin;
    logic [7:0] dlt;
    logic       err;
  } exp_t;

  logic clock    = 1'b0;
  logic slow_clk = 1'b0;
  logic reset    = 1'b1;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t exp_q[C][$];

  always #(Half) clock = ~clock;
  always #157 slow_clk = ~slow_clk;  // period ratio ~pi against the destination clock

  multichannel_gray_synchronizer_if #(.WIDTH(W), .CHANNELS(C)) bus ();

  multichannel_gray_synchronizer #(
    .WIDTH    (W),
    .STAGES   (S),
    .CHANNELS (C)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic set_gray(input int c, input logic [7:0] g);
    bus.gray_in[c*W +: W] = g;
  endtask

  task automatic expect_out(input int c, input logic [7:0] b, input logic [7:0] d,
                            input logic e);
    exp_t x;
    x.bin = b;
    x.dlt = d;
    x.err = e;
    exp_q[c].push_back(x);
  endtask

  task automatic wait_drain();
    int k = 0;
    do begin
      @(negedge clock);
      k++;
    end while ((exp_q[0].size() + exp_q[1].size() + exp_q[2].size() + exp_q[3].size()) != 0
               && k < 20);
    for (int c = 0; c < C; c++) begin
      check($sformatf("drain_ch%0d", c), exp_q[c].size(), 0);
    end
  endtask

  // Monitor: every change strobe pops the channel's next expected response.
  always @(negedge clock) begin
    if (!reset) begin
      for (int c = 0; c < C; c++) begin
        if (bus.change[c]) begin
          if (exp_q[c].size() == 0) begin
            check($sformatf("unexpected_change_ch%0d", c), 1, 0);
          end else begin
            exp_t e;
            e = exp_q[c].pop_front();
            check($sformatf("binary_ch%0d", c), bus.binary_out[c*W +: W], e.bin);
            check($sformatf("delta_ch%0d", c), bus.delta[c*W +: W], e.dlt);
            check($sformatf("error_ch%0d", c), bus.error[c], e.err);
          end
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    n_bad++;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

  initial begin
    int nchg;
    bus.gray_in     = '0;
    bus.error_clear = '0;
    reset           = 1'b1;
    repeat (3) @(negedge clock);
    check("rst_binary", bus.binary_out, 0);
    check("rst_delta", bus.delta, 0);
    check("rst_change", bus.change, 0);
    check("rst_error", bus.error, 0);

    reset = 1'b0;
    repeat (5) @(negedge clock);
    check("idle_change", bus.change, 0);

    // ch0 counts 1..255 from the slow asynchronous clock
    for (int i = 1; i < 256; i++) begin
      @(posedge slow_clk);
      set_gray(0, 8'(i ^ (i >> 1)));
      expect_out(0, 8'(i), 8'h01, 1'b0);
    end
    wait_drain();
    check("count_error", bus.error, 0);

    // ch1 to binary 255, then wrap to 0 with a latency check
    set_gray(1, 8'h80);
    expect_out(1, 8'hFF, 8'hFF, 1'b0);
    wait_drain();
    set_gray(1, 8'h00);
    expect_out(1, 8'h00, 8'h01, 1'b0);
    @(negedge clock);
    @(negedge clock);
    check("latency_early", bus.change[1], 0);
    @(negedge clock);
    check("latency_edge", bus.change[1], 1);
    wait_drain();

    // ch2 multi-bit jump, clear, then jump with coincident clear
    set_gray(2, 8'h03);
    expect_out(2, 8'h02, 8'h02, 1'b1);
    wait_drain();
    check("jump_error_isolated", bus.error, 4'b0100);
    bus.error_clear[2] = 1'b1;
    @(negedge clock);
    bus.error_clear[2] = 1'b0;
    check("error_cleared", bus.error[2], 0);
    set_gray(2, 8'h0C);
    expect_out(2, 8'h08, 8'h06, 1'b1);
    @(negedge clock);
    @(negedge clock);
    bus.error_clear[2] = 1'b1;
    @(negedge clock);
    bus.error_clear[2] = 1'b0;
    wait_drain();
    check("set_wins", bus.error[2], 1);
    bus.error_clear[2] = 1'b1;
    @(negedge clock);
    bus.error_clear[2] = 1'b0;
    check("error_recleared", bus.error, 0);

    // ch3 walk up to binary 5 by legal steps, then back to 4
    set_gray(3, 8'h01); expect_out(3, 8'h01, 8'h01, 1'b0); wait_drain();
    set_gray(3, 8'h03); expect_out(3, 8'h02, 8'h01, 1'b0); wait_drain();
    set_gray(3, 8'h02); expect_out(3, 8'h03, 8'h01, 1'b0); wait_drain();
    set_gray(3, 8'h06); expect_out(3, 8'h04, 8'h01, 1'b0); wait_drain();
    set_gray(3, 8'h07); expect_out(3, 8'h05, 8'h01, 1'b0); wait_drain();
    set_gray(3, 8'h06); expect_out(3, 8'h04, 8'hFF, 1'b0); wait_drain();
    check("backward_error", bus.error[3], 0);
    nchg = 0;
    repeat (100) begin
      @(negedge clock);
      if (bus.change[3]) nchg++;
    end
    check("hold_no_change", nchg, 0);

    // all channels move on the same edge
    bus.gray_in = {8'h05, 8'h0D, 8'h01, 8'hC0};
    expect_out(0, 8'h80, 8'h81, 1'b0);
    expect_out(1, 8'h01, 8'h01, 1'b0);
    expect_out(2, 8'h09, 8'h01, 1'b0);
    expect_out(3, 8'h06, 8'h02, 1'b1);
    wait_drain();
    check("indep_error", bus.error, 4'b1000);

    // reset mid-run with all-ones gray input
    #(Half / 5);
    bus.gray_in = {4{8'hFF}};
    reset       = 1'b1;
    #1;
    check("midrst_binary", bus.binary_out, 0);
    check("midrst_delta", bus.delta, 0);
    check("midrst_change", bus.change, 0);
    check("midrst_error", bus.error, 0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    for (int c = 0; c < C; c++) expect_out(c, 8'hAA, 8'hAA, 1'b1);
    wait_drain();
    check("post_rst_error", bus.error, 4'hF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
